udp_tx_packetizer: RTL and testbench

//  - User-side transmitter for the UDP stack send port (drives send_len/data/last/valid, obeys send_ready).
//  - Buffers a free-running byte stream (e.g. audio samples) in an internal FIFO.
//  - Emits fixed-length UDP payload frames as contiguous bursts, because the stack has no per-byte backpressure.

---
 rtl/udp_tx_packetizer.sv | 165 ++++++++++++++++
 tb/tb_udp_tx_packetizer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_packetizer.sv
// Buffers a byte stream and sends it as fixed-length UDP payload frames. Each frame is one contiguous burst.
// Latency: the first byte appears 1 cycle after the start decision. Backpressure: o_ready is low when the FIFO is full (bytes offered then are dropped); frames start only on i_send_ready.
// Optional UDP_TX_TIMEOUT_EN: after P_TIMEOUT idle cycles, a partial frame is flushed.
module udp_tx_packetizer #(
  parameter int P_PKT_LEN = 1024,
  parameter int P_FIFO_AW = 11,
  parameter int P_IFG     = 12,
  parameter int P_TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [15:0] o_send_len,
  output logic [7:0]  o_send_data,
  output logic        o_send_last,
  output logic        o_send_valid,
  input  logic        i_send_ready,
  output logic        o_overflow,
  output logic [15:0] o_frame_cnt
);
  localparam logic [P_FIFO_AW:0] DEPTH_C = {1'b1, {P_FIFO_AW{1'b0}}};
  localparam logic [P_FIFO_AW:0] PKT_C   = (P_FIFO_AW+1)'(P_PKT_LEN);
  localparam logic [P_FIFO_AW:0] ONE_C   = (P_FIFO_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [7:0]           mem_q [DEPTH_C];
  state_t               state_q, state_d;
  logic [P_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [P_FIFO_AW:0]   count_q, count_d, start_len;
  logic [15:0]          send_len_q, send_len_d, sent_q, sent_d, gap_q, gap_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]           send_data_q, send_data_d;
  logic                 send_last_q, send_last_d, send_valid_q, send_valid_d;
  logic                 wr_en, rd_en, start, flush_req;

  assign wr_en     = i_valid && (count_q < DEPTH_C);
  assign start_len = (count_q >= PKT_C) ? PKT_C : count_q;
  assign start     = (state_q == IDLE) && ((count_q >= PKT_C) || flush_req) && i_send_ready;

`ifdef UDP_TX_TIMEOUT_EN
  logic [31:0] tmr_q, tmr_d;
  logic        flush_q, flush_d;
  assign flush_req = flush_q;

  always_comb begin
    tmr_d   = tmr_q;
    flush_d = flush_q;
    if (start || wr_en) begin
      tmr_d = '0;
    end else if (state_q == IDLE && count_q != '0 && count_q < PKT_C && tmr_q < 32'(P_TIMEOUT)) begin
      tmr_d = tmr_q + 32'd1;
    end
    if (tmr_d >= 32'(P_TIMEOUT)) flush_d = 1'b1;
    if (start) flush_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmr_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      flush_q <= flush_d;
    end
  end
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    send_len_d   = send_len_q;
    send_data_d  = send_data_q;
    send_last_d  = send_last_q;
    send_valid_d = send_valid_q;
    sent_d       = sent_q;
    gap_d        = gap_q;
    frame_cnt_d  = frame_cnt_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SEND;
          send_len_d   = 16'(start_len);
          rd_en        = 1'b1;
          send_valid_d = 1'b1;
          send_data_d  = mem_q[rd_ptr_q];
          sent_d       = 16'd1;
          send_last_d  = (start_len == ONE_C);
        end
      end
      SEND: begin
        if (send_last_q) begin
          state_d      = GAP;
          send_valid_d = 1'b0;
          send_last_d  = 1'b0;
          send_len_d   = '0;
          send_data_d  = '0;
          gap_d        = '0;
        end else begin
          rd_en       = 1'b1;
          send_data_d = mem_q[rd_ptr_q];
          sent_d      = sent_q + 16'd1;
          send_last_d = (sent_q + 16'd1 == send_len_q);
        end
      end
      GAP: begin
        if (gap_q == 16'(P_IFG - 1)) state_d = IDLE;
        else                         gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // The counter advances when the last byte is registered, so it is already updated while o_send_last is high.
    if (send_last_d && !send_last_q) frame_cnt_d = frame_cnt_q + 16'd1;

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en)      count_d = count_q + ONE_C;
    else if (!wr_en && rd_en) count_d = count_q - ONE_C;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      send_len_q   <= '0;
      send_data_q  <= '0;
      send_last_q  <= 1'b0;
      send_valid_q <= 1'b0;
      sent_q       <= '0;
      gap_q        <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      send_len_q   <= send_len_d;
      send_data_q  <= send_data_d;
      send_last_q  <= send_last_d;
      send_valid_q <= send_valid_d;
      sent_q       <= sent_d;
      gap_q        <= gap_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign o_ready      = (count_q < DEPTH_C);
  assign o_overflow   = i_valid && !o_ready;
  assign o_send_len   = send_len_q;
  assign o_send_data  = send_data_q;
  assign o_send_last  = send_last_q;
  assign o_send_valid = send_valid_q;
  assign o_frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench for udp_tx_packetizer (16-byte frames, 32-deep FIFO, 4-cycle gap, 50-cycle timeout).
// A negedge monitor collects frame bytes; all checks are made in the main sequence.
module tb_udp_tx_packetizer;
  localparam int TMO =
`ifdef UDP_TX_TIMEOUT_EN
    1;
`else
    0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_send_ready = 1'b0;
  logic        o_ready, o_send_last, o_send_valid, o_overflow;
  logic [15:0] o_send_len, o_frame_cnt;
  logic [7:0]  o_send_data;

  udp_tx_packetizer #(.P_PKT_LEN(16), .P_FIFO_AW(5), .P_IFG(4), .P_TIMEOUT(50)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_send_len(o_send_len), .o_send_data(o_send_data), .o_send_last(o_send_last),
    .o_send_valid(o_send_valid), .i_send_ready(i_send_ready), .o_overflow(o_overflow),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_cnt  = 0;

  // Frame monitor: records payload bytes and counts protocol violations.
  logic [7:0] rx_q [$];
  int frames_seen, nb, cur_len, idle_cnt, mon_err, last_len;
  bit in_frame, have_prev;

  always @(negedge i_clk) begin
    if (i_rst) begin
      rx_q.delete();
      frames_seen = 0; nb = 0; cur_len = 0; idle_cnt = 0; mon_err = 0; last_len = 0;
      in_frame = 1'b0; have_prev = 1'b0;
    end else if (o_send_valid) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        nb = 0;
        cur_len = int'(o_send_len);
        if (have_prev && idle_cnt < 4) mon_err++;
      end
      if (int'(o_send_len) != cur_len) mon_err++;
      rx_q.push_back(o_send_data);
      nb++;
      if (o_send_last != (nb == cur_len)) mon_err++;
      if (o_send_last) begin
        in_frame = 1'b0;
        frames_seen++;
        last_len = cur_len;
        have_prev = 1'b1;
        idle_cnt = 0;
      end
    end else begin
      if (in_frame) begin
        mon_err++;
        in_frame = 1'b0;
      end
      if (o_send_last || o_send_len != 16'd0) mon_err++;
      idle_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_send_ready = 1'b0; ovf_cnt = 0;
    tick(2);
    i_rst = 1'b0;
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = base + 8'(i);
      @(negedge i_clk);
      if (o_overflow) ovf_cnt++;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  task automatic wait_frames(input string name, input int target, input int budget, output int waited);
    waited = 0;
    while (frames_seen < target && waited < budget) begin
      tick(1);
      waited++;
    end
    if (frames_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: frames=%0d, expected %0d", name, frames_seen, target);
    end
  endtask

  task automatic check_rx(input string name, input int n, input logic [7:0] base);
    int bad = -1;
    logic [7:0] e;
    if (rx_q.size() < n) bad = rx_q.size();
    else for (int i = 0; i < n; i++) begin
      e = base + 8'(i);
      if (bad < 0 && rx_q[i] !== e) bad = i;
    end
    chk({name, " first bad byte idx"}, bad, -1);
  endtask

  typedef struct {
    string      name;
    int         n;
    logic [7:0] base;
    int         exp_frames;
    int         exp_rx;
    int         exp_last_len;
  } vec_t;

  vec_t vecs [5];
  int waited;

  initial begin
    vecs[0] = '{"one_frame",  16, 8'h00, 1,       16,          16};
    vecs[1] = '{"forty",      40, 8'h40, 2 + TMO, 32 + 8*TMO,  TMO ? 8 : 16};
    vecs[2] = '{"fifteen",    15, 8'h80, TMO,     15*TMO,      TMO ? 15 : 0};
    vecs[3] = '{"two_frames", 32, 8'hA0, 2,       32,          16};
    vecs[4] = '{"single",      1, 8'hF0, TMO,     TMO,         TMO};

    do_reset();
    chk("rst valid", int'(o_send_valid), 0);
    chk("rst last", int'(o_send_last), 0);
    chk("rst len", int'(o_send_len), 0);
    chk("rst data", int'(o_send_data), 0);
    chk("rst ready", int'(o_ready), 1);
    chk("rst overflow", int'(o_overflow), 0);
    chk("rst frame_cnt", int'(o_frame_cnt), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      i_send_ready = 1'b1;
      write_bytes(vecs[v].n, vecs[v].base);
      tick(150);
      chk({vecs[v].name, " frames"}, frames_seen, vecs[v].exp_frames);
      chk({vecs[v].name, " frame_cnt"}, int'(o_frame_cnt), vecs[v].exp_frames);
      chk({vecs[v].name, " rx bytes"}, rx_q.size(), vecs[v].exp_rx);
      check_rx(vecs[v].name, vecs[v].exp_rx, vecs[v].base);
      chk({vecs[v].name, " protocol errs"}, mon_err, 0);
      chk({vecs[v].name, " last len"}, last_len, vecs[v].exp_last_len);
      chk({vecs[v].name, " ready"}, int'(o_ready), 1);
    end

    // Full FIFO with the stack not ready: 33rd byte dropped, start 1 cycle after ready.
    do_reset();
    write_bytes(32, 8'h00);
    chk("full ready", int'(o_ready), 0);
    chk("no ovf before full", ovf_cnt, 0);
    write_bytes(1, 8'h20);
    chk("ovf pulses", ovf_cnt, 1);
    tick(3);
    chk("held while not ready", int'(o_send_valid), 0);
    i_send_ready = 1'b1;
    @(negedge i_clk);
    chk("no start before decision edge", int'(o_send_valid), 0);
    @(negedge i_clk);
    chk("start valid", int'(o_send_valid), 1);
    chk("start len", int'(o_send_len), 16);
    chk("start data", int'(o_send_data), 0);
    @(posedge i_clk);
    #1;
    wait_frames("ovf frames", 2, 200, waited);
    tick(20);
    chk("ovf frame count", frames_seen, 2);
    check_rx("ovf", 32, 8'h00);
    chk("ovf protocol errs", mon_err, 0);

    // Reset on the 5th byte of a frame.
    do_reset();
    i_send_ready = 1'b1;
    write_bytes(16, 8'h30);
    waited = 0;
    forever begin
      @(negedge i_clk);
      waited++;
      if ((o_send_valid && o_send_data == 8'h34) || waited > 60) break;
    end
    chk("5th byte seen", int'(waited <= 60), 1);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst valid", int'(o_send_valid), 0);
    chk("midrst last", int'(o_send_last), 0);
    chk("midrst ready", int'(o_ready), 1);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    write_bytes(15, 8'h50);
    tick(40);
    chk("midrst no early frame", frames_seen, 0);
    write_bytes(1, 8'h5F);
    wait_frames("midrst frame", 1, 100, waited);
    check_rx("midrst", 16, 8'h50);
    chk("midrst frame_cnt", int'(o_frame_cnt), 1);

    // Write while the frame starts at count 16: order must be preserved.
    do_reset();
    write_bytes(16, 8'hC0);
    i_send_ready = 1'b1;
    write_bytes(16, 8'hD0);
    wait_frames("simul frames", 2, 200, waited);
    check_rx("simul", 32, 8'hC0);
    chk("simul protocol errs", mon_err, 0);
    chk("simul frame_cnt", int'(o_frame_cnt), 2);

    do_reset();
    i_send_ready = 1'b1;
    write_bytes(5, 8'hE0);
`ifdef UDP_TX_TIMEOUT_EN
    wait_frames("flush frame", 1, 300, waited);
    chk("flush not early", int'(waited >= 50), 1);
    chk("flush len", last_len, 5);
    check_rx("flush", 5, 8'hE0);
    chk("flush frame_cnt", int'(o_frame_cnt), 1);
`else
    tick(150);
    chk("residual not sent", frames_seen, 0);
    chk("residual frame_cnt", int'(o_frame_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
